// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bus between the PC sequencer and the hazard/branch logic
// in ID plus the PC and IF/ID pipeline registers.
//   slave  : the sequencer side (consumes ID requests, drives PC/IF/ID controls)
//   master : the ID/datapath side
interface pc_sequencer_if;
    logic [31:0] pc_i;
    logic        stall_req_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        halt_i;
    logic [31:0] pc_next_o;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;

    modport slave (
        input  pc_i, stall_req_i, branch_taken_i, branch_target_i, halt_i,
        output pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o
    );

    modport master (
        output pc_i, stall_req_i, branch_taken_i, branch_target_i, halt_i,
        input  pc_next_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: front-end sequencer deciding each cycle whether the PC loads
// and with what, and driving the IF/ID write/flush and ID/EX bubble controls.
// Arbitrates sequential fetch, taken-branch redirect, load-use stall and halt
// drain. Optional stall watchdog enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer #(
    parameter int DRAIN_CYCLES = 4,
    parameter int STALL_LIMIT  = 15,
    parameter int CNT_W        = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    pc_sequencer_if.slave    bus,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > (1 << CNT_W) ||
        STALL_LIMIT < 1 || STALL_LIMIT > (1 << CNT_W) - 1) begin : g_bad_params
        $error("pc_sequencer: DRAIN_CYCLES/STALL_LIMIT out of range for CNT_W");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_next;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_cnt_next;
    logic             r_done;
    logic             w_done_next;
    logic [31:0]      w_pc_next;
    logic             w_pc_write;
    logic             w_ifid_write;
    logic             w_ifid_flush;
    logic             w_idex_bubble;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] LP_STALL_LIMIT = CNT_W'(STALL_LIMIT);
    logic             r_err;
    logic             w_err_next;
`endif

    // State and counter registers; reset drops straight back to IDLE with
    // counters cleared and no done pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
`ifdef PC_SEQ_WATCHDOG_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_done      <= w_done_next;
`ifdef PC_SEQ_WATCHDOG_EN
            r_err       <= w_err_next;
`endif
        end
    end

    // Next-state and combinational PC/pipeline controls; stall outranks
    // branch and halt because ID re-evaluates once the hazard clears.
    always_comb begin
        w_pc_next        = bus.pc_i;
        w_pc_write       = 1'b0;
        w_ifid_write     = 1'b0;
        w_ifid_flush     = 1'b0;
        w_idex_bubble    = 1'b0;
        w_state_next     = r_state;
        w_stall_cnt_next = r_stall_cnt;
        w_drain_cnt_next = r_drain_cnt;
        w_done_next      = 1'b0;
`ifdef PC_SEQ_WATCHDOG_EN
        w_err_next       = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!start_i) begin
                    w_state_next     = ST_IDLE;
                    w_stall_cnt_next = '0;
                end else if (bus.stall_req_i) begin
                    w_idex_bubble    = 1'b1;
                    w_stall_cnt_next = (r_stall_cnt == LP_CNT_MAX) ? r_stall_cnt
                                                                   : r_stall_cnt + 1'b1;
`ifdef PC_SEQ_WATCHDOG_EN
                    if (w_stall_cnt_next == LP_STALL_LIMIT) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_HALTED;
                    end
`endif
                end else begin
                    w_pc_write       = 1'b1;
                    w_ifid_write     = 1'b1;
                    w_stall_cnt_next = '0;
                    if (bus.branch_taken_i) begin
                        w_ifid_flush = 1'b1;
                        w_pc_next    = bus.branch_target_i;
                    end else begin
                        w_pc_next    = bus.pc_i + 32'd4;
                    end
                    // The halting instruction itself still advances.
                    if (bus.halt_i) begin
                        w_state_next     = ST_DRAIN;
                        w_drain_cnt_next = '0;
                    end
                end
            end
            ST_DRAIN: begin
                w_ifid_write     = 1'b1;
                w_ifid_flush     = 1'b1;
                w_drain_cnt_next = r_drain_cnt + 1'b1;
                if (r_drain_cnt == LP_DRAIN_LAST) begin
                    w_state_next = ST_HALTED;
                    w_done_next  = 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.pc_next_o     = w_pc_next;
    assign bus.pc_write_o    = w_pc_write;
    assign bus.ifid_write_o  = w_ifid_write;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_bubble_o = w_idex_bubble;
    assign state_o           = r_state;
    assign stall_cnt_o       = r_stall_cnt;
    assign done_o            = r_done;
`ifdef PC_SEQ_WATCHDOG_EN
    assign err_o             = r_err;
`else
    assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer with hand-computed
// expected values. Watchdog expectations follow PC_SEQ_WATCHDOG_EN.
module tb_pc_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] state_o;
    logic [3:0] stall_cnt_o;
    logic       done_o;
    logic       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer_if bus();

    pc_sequencer #(.DRAIN_CYCLES(4), .STALL_LIMIT(15), .CNT_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .bus         (bus),
        .state_o     (state_o),
        .stall_cnt_o (stall_cnt_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic stall, input logic br, input logic [31:0] tgt,
                         input logic halt, input logic [31:0] pc);
        bus.stall_req_i     = stall;
        bus.branch_taken_i  = br;
        bus.branch_target_i = tgt;
        bus.halt_i          = halt;
        bus.pc_i            = pc;
        #1;
    endtask

    // Reset, release, and enter RUN (one IDLE cycle with start_i high).
    task automatic reset_and_start();
        rst_i   = 1'b0;
        start_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        rst_i   = 1'b1;
        start_i = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] pc;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h1234);

        // Reset values and IDLE defaults.
        tick();
        tick();
        check_val("rst_state", state_o, 2'd0);
        check_val("rst_stall_cnt", stall_cnt_o, 4'd0);
        check_val("rst_done", done_o, 1'b0);
        check_val("rst_err", err_o, 1'b0);
        check_val("rst_pc_next", bus.pc_next_o, 32'h1234);
        check_val("rst_pc_write", bus.pc_write_o, 1'b0);
        rst_i = 1'b1;
        tick();
        check_val("idle_hold", state_o, 2'd0);

        // Start: no PC write in the IDLE cycle, then sequential fetch.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        start_i = 1'b1;
        #1;
        check_val("idle_start_pcw", bus.pc_write_o, 1'b0);
        tick();
        check_val("run_state", state_o, 2'd1);
        pc = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, pc);
            check_val($sformatf("seq_pc_next_%0d", i), bus.pc_next_o, 32'(4 * i));
            check_val($sformatf("seq_pc_write_%0d", i), bus.pc_write_o, 1'b1);
            check_val($sformatf("seq_ifid_write_%0d", i), bus.ifid_write_o, 1'b1);
            pc = 32'(4 * i);
            tick();
        end

        // Taken branch redirect, then sequential from the target.
        drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h10);
        check_val("br_pc_next", bus.pc_next_o, 32'h40);
        check_val("br_pc_write", bus.pc_write_o, 1'b1);
        check_val("br_flush", bus.ifid_flush_o, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h40);
        check_val("after_br_pc_next", bus.pc_next_o, 32'h44);
        check_val("after_br_flush", bus.ifid_flush_o, 1'b0);
        tick();

        // Stall with a concurrent branch: stall wins for 3 cycles.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 32'h80, 1'b0, 32'h44);
            check_val($sformatf("stall_pcw_%0d", i), bus.pc_write_o, 1'b0);
            check_val($sformatf("stall_bubble_%0d", i), bus.idex_bubble_o, 1'b1);
            check_val($sformatf("stall_flush_%0d", i), bus.ifid_flush_o, 1'b0);
            check_val($sformatf("stall_pc_next_%0d", i), bus.pc_next_o, 32'h44);
            tick();
            check_val($sformatf("stall_cnt_%0d", i), stall_cnt_o, 32'(i));
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h44);
        check_val("unstall_pcw", bus.pc_write_o, 1'b1);
        check_val("unstall_bubble", bus.idex_bubble_o, 1'b0);
        tick();
        check_val("unstall_cnt", stall_cnt_o, 4'd0);

        // Drop start_i while a stall count is held: back to IDLE, count cleared.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h48);
        tick();
        check_val("pre_stop_cnt", stall_cnt_o, 4'd1);
        start_i = 1'b0;
        #1;
        check_val("stop_pcw", bus.pc_write_o, 1'b0);
        tick();
        check_val("stop_state", state_o, 2'd0);
        check_val("stop_cnt", stall_cnt_o, 4'd0);
        start_i = 1'b1;
        tick();

        // PC wrap at the top of the address space.
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC);
        check_val("wrap_pc_next", bus.pc_next_o, 32'h0);
        tick();

        // Asynchronous reset mid-stall.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        check_val("mid_stall_cnt", stall_cnt_o, 4'd2);
        rst_i = 1'b0;
        #1;
        check_val("rst_stall_state", state_o, 2'd0);
        check_val("rst_stall_cnt2", stall_cnt_o, 4'd0);

        // Halt and drain; start_i dropped during the drain is ignored.
        reset_and_start();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        check_val("halt_pcw", bus.pc_write_o, 1'b1);
        check_val("halt_pc_next", bus.pc_next_o, 32'h24);
        tick();
        start_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h24);
            check_val($sformatf("drain_state_%0d", i), state_o, 2'd2);
            check_val($sformatf("drain_flush_%0d", i), bus.ifid_flush_o, 1'b1);
            check_val($sformatf("drain_pcw_%0d", i), bus.pc_write_o, 1'b0);
            check_val($sformatf("drain_ifidw_%0d", i), bus.ifid_write_o, 1'b1);
            check_val($sformatf("drain_done_%0d", i), done_o, 1'b0);
            tick();
        end
        check_val("halted_state", state_o, 2'd3);
        check_val("halted_done", done_o, 1'b1);
        start_i = 1'b1;
        tick();
        check_val("halted_done_off", done_o, 1'b0);
        check_val("halted_stay", state_o, 2'd3);
        check_val("halted_pcw", bus.pc_write_o, 1'b0);
        check_val("halted_flush", bus.ifid_flush_o, 1'b0);

        // Asynchronous reset mid-drain: no done pulse afterwards.
        reset_and_start();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h30);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h34);
        tick();
        check_val("mid_drain_state", state_o, 2'd2);
        rst_i   = 1'b0;
        start_i = 1'b0;
        #1;
        check_val("rst_drain_state", state_o, 2'd0);
        tick();
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("post_rst_done_%0d", i), done_o, 1'b0);
        end
        check_val("post_rst_state", state_o, 2'd0);

        // Long stall: watchdog trip or saturation depending on the build.
        reset_and_start();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h50);
        for (int k = 1; k <= 17; k++) begin
            tick();
`ifdef PC_SEQ_WATCHDOG_EN
            if (k < 15) begin
                check_val($sformatf("wd_state_%0d", k), state_o, 2'd1);
                check_val($sformatf("wd_err_%0d", k), err_o, 1'b0);
            end else begin
                check_val($sformatf("wd_state_%0d", k), state_o, 2'd3);
                check_val($sformatf("wd_err_%0d", k), err_o, 1'b1);
            end
            check_val($sformatf("wd_done_%0d", k), done_o, 1'b0);
`else
            check_val($sformatf("sat_cnt_%0d", k), stall_cnt_o, (k > 15) ? 32'd15 : 32'(k));
            check_val($sformatf("sat_state_%0d", k), state_o, 2'd1);
            check_val($sformatf("sat_err_%0d", k), err_o, 1'b0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Front-end sequencer for the pipelined CPU: decides every cycle whether the program counter register loads and what value it loads. It drives the PC write enable and next-PC value, plus the IF/ID write, IF/ID flush and ID/EX bubble controls. It arbitrates between sequential fetch, taken-branch redirect, load-use stall and halt drain, and optionally trips a stall watchdog. It sits between the hazard-detection/branch logic in ID and the PC and IF/ID registers.

## Interface
- DRAIN_CYCLES, 4: cycles of NOP injection after halt before done (pipeline depth behind IF).
- STALL_LIMIT, 15: consecutive stall cycles that trip the watchdog (1..2^CNT_W-1).
- CNT_W, 4: width of the stall and drain counters.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  run enable; low pauses fetch.
- pc_i  in  32  current PC register value.
- stall_req_i  in  1  load-use hazard from the hazard unit.
- branch_taken_i  in  1  branch resolved taken in ID.
- branch_target_i  in  32  branch target address.
- halt_i  in  1  halt instruction decoded in ID.
- pc_next_o  out  32  value for the PC register input.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- idex_bubble_o  out  1  zero ID/EX control fields.
- state_o  out  2  FSM state: IDLE=0, RUN=1, DRAIN=2, HALTED=3.
- stall_cnt_o  out  CNT_W  consecutive-stall count.
- done_o  out  1  one-cycle pulse on entry to HALTED after a drain.
- err_o  out  1  sticky watchdog error.

## Operation
- Registered state: FSM, stall_cnt, drain_cnt, done_o, err_o. All other outputs are combinational from state and inputs.
- Default combinational outputs: pc_next_o=pc_i; pc_write_o, ifid_write_o, ifid_flush_o and idex_bubble_o all 0.
- IDLE: defaults. If start_i=1, go to RUN.
- RUN: the first matching condition applies.
  - start_i=0: defaults; next state IDLE; stall_cnt cleared.
  - stall_req_i=1: defaults plus idex_bubble_o=1; stall_cnt increments, saturating at 2^CNT_W-1. branch_taken_i and halt_i are ignored, because ID re-evaluates.
  - branch_taken_i=1: pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, pc_next_o=branch_target_i.
  - Otherwise: pc_write_o=1, ifid_write_o=1, pc_next_o=pc_i+4, truncated to 32 bits so 0xFFFFFFFC wraps to 0.
  - In the branch and sequential cases, stall_cnt clears.
  - In the branch and sequential cases, halt_i=1 also sets next state DRAIN and clears drain_cnt. The halting instruction still advances this cycle.
- DRAIN: pc_write_o=0, ifid_write_o=1, ifid_flush_o=1. drain_cnt increments. In the cycle where drain_cnt=DRAIN_CYCLES-1, next state is HALTED and done_o=1 for the next cycle only. start_i is ignored.
- HALTED: defaults. Exits only via reset.

## Timing
- Reset values: state IDLE, stall_cnt 0, drain_cnt 0, done_o 0, err_o 0. Combinational outputs then take the IDLE defaults, with pc_next_o=pc_i.
- Redirect and stall controls act in the same cycle as their request, with zero-cycle latency. The taken-branch penalty is one flushed fetch.
- start_i rising in IDLE: the first pc_write_o=1 occurs the following cycle.
- halt_i accepted at edge N: DRAIN spans cycles N+1 .. N+DRAIN_CYCLES. done_o is high during cycle N+DRAIN_CYCLES+1.
- Reset asserted mid-DRAIN or mid-stall: immediate return to IDLE with counters cleared. No done_o pulse.

## Configuration
- PC_SEQ_WATCHDOG_EN defined:
  - In RUN, a stall cycle that brings stall_cnt to STALL_LIMIT sets err_o=1 (sticky until reset) and next state HALTED.
  - No done_o pulse and no drain occur.
- PC_SEQ_WATCHDOG_EN undefined:
  - err_o is tied to 0.
  - stall_cnt still counts and saturates.
  - Stalls may last indefinitely.

## Test plan
- Reset then start_i=1 with pc_i tracking pc_next_o from 0: pc_next_o sequence is 0x4, 0x8, 0xC, with pc_write_o=1 every cycle starting one cycle after start.
- In RUN with pc_i=0x10, branch_taken_i=1 and target 0x40: pc_next_o=0x40, pc_write_o=1, ifid_flush_o=1 that cycle. The next cycle, with pc_i=0x40, pc_next_o=0x44.
- stall_req_i=1 and branch_taken_i=1 together for 3 cycles: pc_write_o=0, idex_bubble_o=1, ifid_flush_o=0, stall_cnt_o counts 1, 2, 3. It clears on the first non-stall cycle.
- halt_i=1 in RUN with DRAIN_CYCLES=4: state_o=2 for 4 cycles with ifid_flush_o=1 and pc_write_o=0, then state_o=3 and a single-cycle done_o.
- With the macro defined and STALL_LIMIT=15, hold stall_req_i for 15 cycles: err_o=1 and state_o=3, done_o stays 0. With the macro undefined, stall_cnt_o saturates at 15 and state_o stays 1.
- pc_i=0xFFFFFFFC in RUN with no hazard: pc_next_o=0x00000000.
